// File: rtl/uart_tx_sequencer_if.sv
// Host write port, baud generator handshake and serial line of one UART transmitter.
// cfg_parity_odd exists only when UART_TX_PARITY_EN is defined.
interface uart_tx_sequencer_if #(
    parameter int DATA_BITS = 8
);
    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 full;
    logic                 ovf;
    logic [2:0]           cfg_baud_sel;
`ifdef UART_TX_PARITY_EN
    logic                 cfg_parity_odd;
`endif
    logic                 baud_en;
    logic [2:0]           baud_sel;
    logic                 baud_tick;
    logic                 tx;
    logic                 busy;
    logic                 done;

`ifdef UART_TX_PARITY_EN
    modport master (
        output wr_en, wr_data, cfg_baud_sel, cfg_parity_odd, baud_tick,
        input  full, ovf, baud_en, baud_sel, tx, busy, done
    );
    modport slave (
        input  wr_en, wr_data, cfg_baud_sel, cfg_parity_odd, baud_tick,
        output full, ovf, baud_en, baud_sel, tx, busy, done
    );
`else
    modport master (
        output wr_en, wr_data, cfg_baud_sel, baud_tick,
        input  full, ovf, baud_en, baud_sel, tx, busy, done
    );
    modport slave (
        input  wr_en, wr_data, cfg_baud_sel, baud_tick,
        output full, ovf, baud_en, baud_sel, tx, busy, done
    );
`endif
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: byte FIFO feeding a start/data/[parity]/stop serialiser paced by baud ticks.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_sequencer #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input logic                Clk,
    input logic                Rst,
    uart_tx_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;
`endif

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic                 push, pop, empty;
    logic [DATA_BITS-1:0] head;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 tx_n, baud_en_n, done_n;
    logic [2:0]           baud_sel_n;
`ifdef UART_TX_PARITY_EN
    logic                 parity_odd, parity_bit;
`endif

    assign bus.full = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = bus.wr_en && !bus.full;
    assign head     = mem[rd_ptr];

    // NOTE: the storage array has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            bus.ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            bus.ovf <= bus.wr_en && bus.full;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        tx_n       = bus.tx;
        baud_en_n  = bus.baud_en;
        baud_sel_n = bus.baud_sel;
        done_n     = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    state_n    = SYNC;
                    baud_en_n  = 1'b1;
                    baud_sel_n = bus.cfg_baud_sel;
                end
            end
            SYNC: if (bus.baud_tick) begin
                pop     = 1'b1;
                shift_n = head;
                state_n = START;
                tx_n    = 1'b0;
            end
            START: if (bus.baud_tick) begin
                state_n   = DATA;
                bit_cnt_n = '0;
                tx_n      = shift[0];
            end
            DATA: if (bus.baud_tick) begin
                shift_n   = shift >> 1;
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_n    = PARITY;
                    tx_n       = parity_bit;
`else
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                    tx_n       = 1'b1;
`endif
                end else begin
                    tx_n = shift[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bus.baud_tick) begin
                state_n    = STOP;
                stop_cnt_n = 1'b0;
                tx_n       = 1'b1;
            end
`endif
            STOP: if (bus.baud_tick) begin
                if (stop_cnt == 1'(STOP_BITS - 1)) begin
                    done_n = 1'b1;
                    // Back-to-back frames skip SYNC: the generator is already bit-aligned.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        baud_en_n = 1'b0;
                        state_n   = IDLE;
                        tx_n      = 1'b1;
                    end
                end else begin
                    stop_cnt_n = stop_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            shift        <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            bus.tx       <= 1'b1;
            bus.baud_en  <= 1'b0;
            bus.baud_sel <= 3'd0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            state        <= state_n;
            shift        <= shift_n;
            bit_cnt      <= bit_cnt_n;
            stop_cnt     <= stop_cnt_n;
            bus.tx       <= tx_n;
            bus.baud_en  <= baud_en_n;
            bus.baud_sel <= baud_sel_n;
            bus.busy     <= (state_n != IDLE);
            bus.done     <= done_n;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            parity_odd <= 1'b0;
            parity_bit <= 1'b0;
        end else begin
            if (state == IDLE && !empty) parity_odd <= bus.cfg_parity_odd;
            if (pop) parity_bit <= (^head) ^ parity_odd;
        end
    end
`endif
endmodule
